// File: rtl/alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_req_sequencer
// Purpose  : Time-shares a single registered ALU between N_REQ requesters.
//            A round-robin arbiter grants one request at a time. The granted
//            operation is driven into the ALU for exactly one cycle. The
//            registered result is then returned over a valid/ready response
//            channel, tagged with the requester id. Hold opcodes are rejected
//            without ever enabling the ALU.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            req_valid/ready    - per-requester request handshake (ready one-hot)
//            req_a/b/grp/op     - packed per-requester operands and opcode
//            alu_*              - operand/opcode/enable drive into the ALU
//            alu_out            - registered ALU result
//            rsp_valid/ready    - response handshake
//            rsp_id/data/err    - response payload
//            busy, ops_done     - status and completed-response counter
// Revision : 1.0 - initial release
// ============================================================================
module alu_req_sequencer #(
    parameter int N_REQ = 2,
    parameter int CNT_W = 16,
    localparam int C_ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*5-1:0]   req_a,
    input  logic [N_REQ*5-1:0]   req_b,
    input  logic [N_REQ-1:0]     req_grp,
    input  logic [N_REQ*3-1:0]   req_op,
    output logic [4:0]           alu_a,
    output logic [4:0]           alu_b,
    output logic [2:0]           alu_a_op,
    output logic [1:0]           alu_b_op,
    output logic                 alu_a_en,
    output logic                 alu_b_en,
    output logic                 alu_en,
    input  logic [5:0]           alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [C_ID_W-1:0]    rsp_id,
    output logic [5:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [C_ID_W-1:0]   rr_q, rr_d;
    logic [4:0]          a_q, a_d;
    logic [4:0]          b_q, b_d;
    logic                grp_q, grp_d;
    logic [2:0]          op_q, op_d;
    logic [C_ID_W-1:0]   id_q, id_d;
    logic [5:0]          rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    ops_done_q, ops_done_d;

    logic                w_grant_found;
    logic [C_ID_W-1:0]   w_grant_id;
    int                  w_sel;
    logic                w_sel_grp;
    logic [2:0]          w_sel_op;
    logic                w_hold;

    // Round-robin search: first valid requester at or above the pointer,
    // wrapping back to 0.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_grant_found && req_valid[(int'(rr_q) + k) % N_REQ]) begin
                w_grant_found = 1'b1;
                w_grant_id    = C_ID_W'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    // Fields of the currently winning requester.
    always_comb begin
        w_sel     = int'(w_grant_id);
        w_sel_grp = req_grp[w_grant_id];
        w_sel_op  = req_op[3*w_sel +: 3];
        // Hold codes: A-group op 7, B-group op[1:0] 3 (bit 2 ignored).
        w_hold    = w_sel_grp ? (w_sel_op[1:0] == 2'd3) : (w_sel_op == 3'd7);
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        a_d        = a_q;
        b_d        = b_q;
        grp_d      = grp_q;
        op_d       = op_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ops_done_d = ops_done_q;
        req_ready  = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_a_op   = '0;
        alu_b_op   = '0;
        alu_a_en   = 1'b0;
        alu_b_en   = 1'b0;
        alu_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Ready only goes to a valid requester, so a ready bit here
                // is always a completed handshake.
                if (w_grant_found) begin
                    req_ready[w_grant_id] = 1'b1;
                    a_d   = req_a[5*w_sel +: 5];
                    b_d   = req_b[5*w_sel +: 5];
                    grp_d = w_sel_grp;
                    op_d  = w_sel_op;
                    id_d  = w_grant_id;
                    rr_d  = (w_grant_id == C_ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
                    if (w_hold) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        state_d    = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                alu_en = 1'b1;
                alu_a  = a_q;
                alu_b  = b_q;
                if (grp_q) begin
                    alu_b_en = 1'b1;
                    alu_b_op = op_q[1:0];
                end else begin
                    alu_a_en = 1'b1;
                    alu_a_op = op_q;
                end
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // ALU result registered on the DRIVE edge is visible now.
                rsp_data_d = alu_out;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            grp_q      <= 1'b0;
            op_q       <= '0;
            id_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            grp_q      <= grp_d;
            op_q       <= op_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            ops_done_q <= ops_done_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_req_sequencer
// Purpose  : Self-checking bench for alu_req_sequencer. A behavioural ALU
//            answers the sequencer's drive; a transaction-level reference
//            model predicts grants, response timing and payloads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_req_sequencer;

    localparam int N  = 2;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*5-1:0]   req_a;
    logic [N*5-1:0]   req_b;
    logic [N-1:0]     req_grp;
    logic [N*3-1:0]   req_op;
    logic [4:0]       alu_a, alu_b;
    logic [2:0]       alu_a_op;
    logic [1:0]       alu_b_op;
    logic             alu_a_en, alu_b_en, alu_en;
    logic [5:0]       alu_out = '0;
    logic             rsp_valid, rsp_ready;
    logic [0:0]       rsp_id;
    logic [5:0]       rsp_data;
    logic             rsp_err, busy;
    logic [CW-1:0]    ops_done;

    always #5 clk = ~clk;

    alu_req_sequencer #(.N_REQ(N), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_grp(req_grp), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
        .alu_a_en(alu_a_en), .alu_b_en(alu_b_en), .alu_en(alu_en),
        .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    // Behavioural ALU: signed 5-bit operands, 6-bit signed result.
    function automatic logic [5:0] alu_f(input logic grp, input logic [2:0] op,
                                         input logic [4:0] a, input logic [4:0] b);
        logic signed [5:0] sa, sb;
        sa = {a[4], a};
        sb = {b[4], b};
        if (!grp) begin
            case (op)
                3'd0:    return sa + sb;
                3'd1:    return sa - sb;
                3'd2:    return sa & sb;
                3'd3:    return sa | sb;
                3'd4:    return sa ^ sb;
                3'd5:    return -sa;
                default: return sb;
            endcase
        end else begin
            case (op[1:0])
                2'd0:    return sa <<< 1;
                2'd1:    return sb >>> 1;
                default: return ~sa;
            endcase
        end
    endfunction

    // Registered ALU; an ambiguous enable pattern yields a marker value.
    always @(posedge clk) begin
        if (alu_en) begin
            if (alu_a_en && !alu_b_en)      alu_out <= alu_f(1'b0, alu_a_op, alu_a, alu_b);
            else if (alu_b_en && !alu_a_en) alu_out <= alu_f(1'b1, {1'b0, alu_b_op}, alu_a, alu_b);
            else                            alu_out <= 6'h2A;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state (one outstanding transaction at most).
    bit          m_busy;
    int          m_acc;
    int          m_id;
    logic        m_grp;
    logic [2:0]  m_op;
    logic [4:0]  m_a, m_b;
    logic        m_err;
    logic [5:0]  m_data;
    int          m_rr;
    int          m_ops;
    int          grant_log[$];
    logic [5:0]  last_data;
    int          last_id;
    logic        last_err;
    int          alu_en_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic g, input logic [2:0] op,
                           input logic [4:0] a, input logic [4:0] b);
        req_valid[i]     = v;
        req_grp[i]       = g;
        req_op[3*i +: 3] = op;
        req_a[5*i +: 5]  = a;
        req_b[5*i +: 5]  = b;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic tick();
        int          w;
        int          age;
        logic [N-1:0] exp_ready;
        logic        exp_valid;
        logic [16:0] exp_alu;
        logic [16:0] got_alu;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
        exp_ready = '0;
        exp_valid = 1'b0;
        exp_alu   = '0;
        age       = 0;
        if (!m_busy) begin
            if (w >= 0) exp_ready[w] = 1'b1;
        end else begin
            age       = cyc - m_acc;
            exp_valid = (age >= (m_err ? 1 : 3));
            if (!m_err && age == 1)
                exp_alu = {m_a, m_b, (m_grp ? 3'd0 : m_op), (m_grp ? m_op[1:0] : 2'd0),
                           !m_grp, m_grp, 1'b1};
        end
        got_alu = {alu_a, alu_b, alu_a_op, alu_b_op, alu_a_en, alu_b_en, alu_en};
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, m_busy);
        check("rsp_valid", rsp_valid, exp_valid);
        check("alu_ports", got_alu, exp_alu);
        check("ops_done", ops_done, m_ops[CW-1:0]);
        if (exp_valid) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_data", rsp_data, m_data);
            check("rsp_err", rsp_err, m_err);
        end
        if (alu_en) alu_en_seen++;

        if (rst) begin
            m_busy = 0;
            m_rr   = 0;
            m_ops  = 0;
            grant_log.delete();
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
            if (w >= 0) begin
                m_busy = 1;
                m_acc  = cyc;
                m_id   = w;
                m_grp  = req_grp[w];
                m_op   = req_op[3*w +: 3];
                m_a    = req_a[5*w +: 5];
                m_b    = req_b[5*w +: 5];
                m_err  = m_grp ? (m_op[1:0] == 2'd3) : (m_op == 3'd7);
                m_data = m_err ? 6'd0 : alu_f(m_grp, m_op, m_a, m_b);
                m_rr   = (w + 1) % N;
            end
        end else if (exp_valid && rsp_ready) begin
            m_busy    = 0;
            m_ops     = m_ops + 1;
            last_data = rsp_data;
            last_id   = int'(rsp_id);
            last_err  = rsp_err;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_grp = '0; req_op = '0;
        rsp_ready = 1'b0;
        m_busy = 0; m_rr = 0; m_ops = 0; m_acc = 0; m_id = 0;
        last_data = '0; last_id = -1; last_err = 1'b0; alu_en_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {req_ready, alu_a, alu_b, alu_a_op, alu_b_op, alu_a_en, alu_b_en,
                              alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, ops_done}, '0);
        rst = 1'b0;

        // Simple add from requester 0.
        set_req(0, 1'b1, 1'b0, 3'd0, 5'd5, 5'd3);
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("t1_data", last_data, 6'd8);
        check("t1_id", last_id, 0);
        check("t1_err", last_err, 1'b0);

        // Fairness between two always-valid requesters after reset.
        rst = 1'b1; tick(); rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 3'd0, 5'd1, 5'd2);
        set_req(1, 1'b1, 1'b0, 3'd0, 5'd3, 5'd4);
        repeat (16) tick();
        req_valid = '0;
        tick();
        check("t2_ngrants", grant_log.size(), 4);
        if (grant_log.size() >= 4)
            for (int i = 0; i < 4; i++) check("t2_grant", grant_log[i], i % 2);
        check("t2_ops", ops_done, 16'd4);

        // Most-negative minus most-positive.
        set_req(1, 1'b1, 1'b0, 3'd1, 5'b10000, 5'b01111);
        tick();
        req_valid = '0;
        repeat (4) tick();
        check("t3_data", last_data, 6'b100001);
        check("t3_id", last_id, 1);

        // Hold codes in both groups never touch the ALU.
        alu_en_seen = 0;
        set_req(0, 1'b1, 1'b0, 3'd7, 5'd3, 5'd2);
        tick();
        req_valid = '0;
        tick();
        check("t4a_err", last_err, 1'b1);
        check("t4a_data", last_data, 6'd0);
        set_req(0, 1'b1, 1'b1, 3'd3, 5'd3, 5'd2);
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t4b_err", last_err, 1'b1);
        check("t4b_data", last_data, 6'd0);
        check("t4_alu_en", alu_en_seen, 0);

        // Back-pressure on the response with other requests pending.
        set_req(0, 1'b1, 1'b0, 3'd2, 5'd7, 5'd9);
        set_req(1, 1'b1, 1'b1, 3'd0, 5'b11101, 5'd6);
        rsp_ready = 1'b0;
        repeat (8) tick();
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Reset while the ALU is being driven.
        set_req(0, 1'b1, 1'b0, 3'd0, 5'd1, 5'd1);
        req_valid[1] = 1'b0;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_zero", {req_ready, alu_a, alu_b, alu_a_op, alu_b_op, alu_a_en, alu_b_en,
                          alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, ops_done}, '0);
        req_valid = 2'b11;
        tick();
        check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        req_valid = '0;
        repeat (4) tick();

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
